// File: rtl/manchester_tx_if.sv
// Word-input handshake between a word source and the Manchester transmitter.
interface manchester_tx_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_pol;

  modport master (
    output in_valid,
    output in_data,
    output in_pol,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_pol,
    output in_ready
  );

endinterface

// File: rtl/manchester_tx.sv
// Manchester line encoder: serialises DATA_W-bit words as half-bit pairs on a registered line,
// streaming back-to-back words with no idle gap.
module manchester_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned HALF_BIT_CYC = 1,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          IDLE_LEVEL   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  manchester_tx_if.slave        in_if,
  output logic                  y,
  output logic                  y_en,
  output logic                  busy,
  output logic                  word_done
);

  localparam int unsigned DivW = (HALF_BIT_CYC > 1) ? $clog2(HALF_BIT_CYC) : 1;
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(HALF_BIT_CYC - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StFirstHalf  = 2'd1,
    StSecondHalf = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DivW-1:0]   r_div_cnt;
  logic [DivW-1:0]   w_div_cnt_nxt;
  logic [BitW-1:0]   r_bit_cnt;
  logic [BitW-1:0]   w_bit_cnt_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              r_pol;
  logic              w_pol_nxt;
  logic              r_y;
  logic              w_y_nxt;
  logic              r_y_en;
  logic              w_y_en_nxt;

  logic              w_div_wrap;
  logic              w_bit_last;
  logic              w_word_end;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_cur_bit_nxt;

  assign w_div_wrap = (r_div_cnt == DivLast);
  assign w_bit_last = (r_bit_cnt == BitLast);
  assign w_word_end = (r_state == StSecondHalf) && w_div_wrap && w_bit_last;
  assign w_in_ready = (r_state == StIdle) || w_word_end;
  assign w_accept   = in_if.in_valid && w_in_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_pol_nxt     = r_pol;

    unique case (r_state)
      StIdle: begin
        w_div_cnt_nxt = '0;
        w_bit_cnt_nxt = '0;
      end
      StFirstHalf: begin
        if (w_div_wrap) begin
          w_state_nxt   = StSecondHalf;
          w_div_cnt_nxt = '0;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 1'b1;
        end
      end
      StSecondHalf: begin
        if (w_div_wrap) begin
          w_div_cnt_nxt = '0;
          if (!w_bit_last) begin
            w_state_nxt   = StFirstHalf;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            w_shift_nxt   = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
          end else begin
            w_state_nxt   = StIdle;
            w_bit_cnt_nxt = '0;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = StIdle;
        w_div_cnt_nxt = '0;
        w_bit_cnt_nxt = '0;
      end
    endcase

    // A new word overrides the end-of-word return to idle, keeping the line continuous.
    if (w_accept) begin
      w_state_nxt   = StFirstHalf;
      w_div_cnt_nxt = '0;
      w_bit_cnt_nxt = '0;
      w_shift_nxt   = in_if.in_data;
      w_pol_nxt     = in_if.in_pol;
    end
  end

  // The line register is loaded from the next state so y shows the new half-bit with no bubble.
  always_comb begin
    w_cur_bit_nxt = MSB_FIRST ? w_shift_nxt[DATA_W-1] : w_shift_nxt[0];
    w_y_nxt       = IDLE_LEVEL;
    w_y_en_nxt    = 1'b0;
    unique case (w_state_nxt)
      StFirstHalf: begin
        w_y_nxt    = ~w_cur_bit_nxt ^ w_pol_nxt;
        w_y_en_nxt = 1'b1;
      end
      StSecondHalf: begin
        w_y_nxt    = w_cur_bit_nxt ^ w_pol_nxt;
        w_y_en_nxt = 1'b1;
      end
      default: begin
        w_y_nxt    = IDLE_LEVEL;
        w_y_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_pol     <= 1'b0;
      r_y       <= IDLE_LEVEL;
      r_y_en    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_pol     <= w_pol_nxt;
      r_y       <= w_y_nxt;
      r_y_en    <= w_y_en_nxt;
    end
  end

  assign in_if.in_ready = w_in_ready;
  assign y              = r_y;
  assign y_en           = r_y_en;
  assign busy           = (r_state != StIdle);
  assign word_done      = w_word_end;

endmodule

// File: tb/tb_manchester_tx.sv
// Bench for manchester_tx: two configurations checked every cycle against a sample scoreboard.
module tb_manchester_tx;

  localparam int WaitLimit = 200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  manchester_tx_if #(.DATA_W(8)) if0 ();
  manchester_tx_if #(.DATA_W(4)) if1 ();

  logic y0, y_en0, busy0, wd0;
  logic y1, y_en1, busy1, wd1;

  manchester_tx #(
    .DATA_W      (8),
    .HALF_BIT_CYC(1),
    .MSB_FIRST   (1'b1),
    .IDLE_LEVEL  (1'b0)
  ) dut0 (
    .clk      (clk),
    .reset    (reset),
    .in_if    (if0.slave),
    .y        (y0),
    .y_en     (y_en0),
    .busy     (busy0),
    .word_done(wd0)
  );

  manchester_tx #(
    .DATA_W      (4),
    .HALF_BIT_CYC(3),
    .MSB_FIRST   (1'b0),
    .IDLE_LEVEL  (1'b1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .in_if    (if1.slave),
    .y        (y1),
    .y_en     (y_en1),
    .busy     (busy1),
    .word_done(wd1)
  );

  typedef struct packed {
    logic y;
    logic done;
  } samp_t;

  samp_t q0[$];
  samp_t q1[$];
  int    checks   = 0;
  int    failures = 0;
  bit    rdy_exp0 = 1'b1;
  bit    rdy_exp1 = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line samples for one word: IEEE pairs are 1->"01", 0->"10"; Thomas inverts.
  task automatic push_word(input int id, input logic [7:0] data, input logic pol);
    int       w;
    int       h;
    logic     b;
    logic [1:0] pair;
    samp_t    s;
    w = (id == 0) ? 8 : 4;
    h = (id == 0) ? 1 : 3;
    for (int i = 0; i < w; i++) begin
      b    = (id == 0) ? data[w-1-i] : data[i];
      pair = b ? 2'b01 : 2'b10;
      if (pol) pair = ~pair;
      for (int j = 0; j < 2 * h; j++) begin
        s.y    = (j < h) ? pair[1] : pair[0];
        s.done = (i == w - 1) && (j == 2 * h - 1);
        if (id == 0) q0.push_back(s);
        else         q1.push_back(s);
      end
    end
  endtask

  task automatic monitor(input int id, input logic y, input logic ye, input logic wd,
                         input logic bsy, input logic rdy, input logic idle_lvl,
                         output bit exp_rdy);
    samp_t s;
    bit    have;
    int    rem;
    string p;
    have = 1'b0;
    s    = '0;
    p    = $sformatf("d%0d", id);
    if (id == 0) begin
      if (q0.size() > 0) begin s = q0.pop_front(); have = 1'b1; end
      rem = q0.size();
    end else begin
      if (q1.size() > 0) begin s = q1.pop_front(); have = 1'b1; end
      rem = q1.size();
    end
    if (have) begin
      check({p, ".y"}, y, s.y);
      check({p, ".y_en"}, ye, 1'b1);
      check({p, ".word_done"}, wd, s.done);
      check({p, ".busy"}, bsy, 1'b1);
    end else begin
      check({p, ".idle_y"}, y, idle_lvl);
      check({p, ".idle_y_en"}, ye, 1'b0);
      check({p, ".idle_word_done"}, wd, 1'b0);
      check({p, ".idle_busy"}, bsy, 1'b0);
    end
    exp_rdy = (rem == 0);
    check({p, ".in_ready"}, rdy, exp_rdy);
  endtask

  // One clock: book any transfer on the coming edge, then check the following cycle.
  task automatic step();
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (if0.in_valid && rdy_exp0) push_word(0, if0.in_data, if0.in_pol);
      if (if1.in_valid && rdy_exp1) push_word(1, {4'b0, if1.in_data}, if1.in_pol);
    end
    @(negedge clk);
    monitor(0, y0, y_en0, wd0, busy0, if0.in_ready, 1'b0, rdy_exp0);
    monitor(1, y1, y_en1, wd1, busy1, if1.in_ready, 1'b1, rdy_exp1);
  endtask

  task automatic send_word(input int id, input logic [7:0] data, input logic pol);
    int n;
    n = 0;
    if (id == 0) begin
      if0.in_valid = 1'b1; if0.in_data = data;      if0.in_pol = pol;
    end else begin
      if1.in_valid = 1'b1; if1.in_data = data[3:0]; if1.in_pol = pol;
    end
    while (!((id == 0) ? if0.in_ready : if1.in_ready) && n < WaitLimit) begin
      step();
      n++;
    end
    check($sformatf("d%0d.wait_ready", id), (id == 0) ? if0.in_ready : if1.in_ready, 1'b1);
    step();
  endtask

  // Idle cycles with the data/polarity inputs scrambled to show they are ignored.
  task automatic idle_cycles(input int n);
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      if0.in_data = 8'($urandom);
      if0.in_pol  = 1'($urandom);
      if1.in_data = 4'($urandom);
      if1.in_pol  = 1'($urandom);
      step();
    end
  endtask

  initial begin
    reset        = 1'b1;
    if0.in_valid = 1'b1; if0.in_data = 8'hA5; if0.in_pol = 1'b0;
    if1.in_valid = 1'b1; if1.in_data = 4'hF;  if1.in_pol = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    idle_cycles(3);

    send_word(0, 8'hA5, 1'b0);
    idle_cycles(20);
    send_word(0, 8'hA5, 1'b1);
    idle_cycles(20);

    send_word(0, 8'hFF, 1'b0);
    send_word(0, 8'h00, 1'b0);
    idle_cycles(36);

    send_word(1, 8'h01, 1'b0);
    idle_cycles(30);
    send_word(1, 8'h0A, 1'b1);
    send_word(1, 8'h06, 1'b0);
    idle_cycles(55);

    // Abort a word mid-flight, then start a fresh one straight out of reset.
    send_word(0, 8'h3C, 1'b0);
    if0.in_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_word(0, 8'h5A, 1'b1);
    idle_cycles(20);

    for (int k = 0; k < 6; k++) begin
      send_word(0, 8'($urandom), 1'($urandom));
      idle_cycles(int'($urandom_range(0, 3)));
    end
    idle_cycles(20);
    for (int k = 0; k < 4; k++) begin
      send_word(1, 8'($urandom), 1'($urandom));
      idle_cycles(int'($urandom_range(0, 3)));
    end
    idle_cycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
